// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, op codes and FSM states for calc_seq_ctrl
package calc_pkg;

  localparam logic [7:0] CH_ADD   = 8'h2B;
  localparam logic [7:0] CH_SUB   = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_CLR_U = 8'h43;
  localparam logic [7:0] CH_CLR_L = 8'h63;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b1000;

  typedef enum logic [2:0] {IDLE, OPA, OPB, EXEC, WAIT, DONE} state_t;

  function automatic logic [3:0] op_code(input logic [7:0] c);
    case (c)
      CH_ADD:  return OP_ADD;
      CH_SUB:  return OP_SUB;
      CH_MUL:  return OP_MUL;
      CH_DIV:  return OP_DIV;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_dec_acc.sv
// rtl/calc_dec_acc.sv - decimal digit accumulator, acc = acc*10 + d truncated to WIDTH
module calc_dec_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             acc_en,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (load)
      acc_d = WIDTH'(digit);
    else if (acc_en)
      acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - calculator sequencer: ASCII operand/operator entry and ALU handshake
// Optional CALC_CHAIN_EN: an operator after a good result reuses that result as operand A.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [3:0]       op_sel,
  output logic             alu_start,
  output logic [WIDTH-1:0] entry,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic             busy
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [3:0]       op_sel_q, op_sel_d;
  logic             err_q, err_d, result_valid_q, result_valid_d;
  logic             digit_seen_q, digit_seen_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             acc_clr, acc_load, acc_en;
  logic [WIDTH-1:0] acc;

  logic       is_dig, is_op, is_eq, is_clr;
  logic [3:0] ch_op;

  assign ch_op  = op_code(rx_data);
  assign is_dig = rx_valid && (rx_data >= CH_0) && (rx_data <= CH_9);
  assign is_op  = rx_valid && (ch_op != OP_NONE);
  assign is_eq  = rx_valid && ((rx_data == CH_EQ) || (rx_data == CH_CR));
  assign is_clr = rx_valid && ((rx_data == CH_CLR_U) || (rx_data == CH_CLR_L));

  calc_dec_acc #(.WIDTH(WIDTH)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .load   (acc_load),
    .acc_en (acc_en),
    .digit  (rx_data[3:0]),
    .acc    (acc)
  );

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_sel_d       = op_sel_q;
    result_d       = result_q;
    err_d          = err_q;
    result_valid_d = 1'b0;
    digit_seen_d   = digit_seen_q;
    timer_d        = timer_q;
    acc_clr        = 1'b0;
    acc_load       = 1'b0;
    acc_en         = 1'b0;
    alu_start      = 1'b0;

    // Clear beats everything, including an in-flight ALU operation.
    if (is_clr) begin
      state_d      = IDLE;
      op_a_d       = '0;
      op_b_d       = '0;
      op_sel_d     = OP_NONE;
      result_d     = '0;
      err_d        = 1'b0;
      digit_seen_d = 1'b0;
      timer_d      = '0;
      acc_clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (is_dig) begin
          acc_load = 1'b1;
          state_d  = OPA;
        end
        OPA: begin
          if (is_dig) begin
            acc_en = 1'b1;
          end else if (is_op) begin
            op_a_d       = acc;
            op_sel_d     = ch_op;
            acc_clr      = 1'b1;
            digit_seen_d = 1'b0;
            state_d      = OPB;
          end
        end
        OPB: begin
          if (is_dig) begin
            acc_en       = 1'b1;
            digit_seen_d = 1'b1;
          end else if (is_op && !digit_seen_q) begin
            op_sel_d = ch_op;
          end else if (is_eq && digit_seen_q) begin
            op_b_d  = acc;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (op_sel_q == OP_DIV && op_b_q == '0) begin
            result_d       = '0;
            err_d          = 1'b1;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            alu_start = 1'b1;
            timer_d   = '0;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (alu_done) begin
            result_d       = alu_result;
            err_d          = alu_err;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else if (timer_q == TW'(ALU_TIMEOUT - 1)) begin
            result_d       = '0;
            err_d          = 1'b1;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        DONE: begin
          if (is_dig) begin
            op_sel_d = OP_NONE;
            acc_load = 1'b1;
            state_d  = OPA;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op && !err_q) begin
            op_a_d       = result_q;
            op_sel_d     = ch_op;
            acc_clr      = 1'b1;
            digit_seen_d = 1'b0;
            state_d      = OPB;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_sel_q       <= OP_NONE;
      result_q       <= '0;
      err_q          <= 1'b0;
      result_valid_q <= 1'b0;
      digit_seen_q   <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_sel_q       <= op_sel_d;
      result_q       <= result_d;
      err_q          <= err_d;
      result_valid_q <= result_valid_d;
      digit_seen_q   <= digit_seen_d;
      timer_q        <= timer_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_sel       = op_sel_q;
  assign entry        = acc;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign busy         = (state_q == EXEC) || (state_q == WAIT);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - scoreboard bench for calc_seq_ctrl (honours CALC_CHAIN_EN)
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int W  = 16;
  localparam int TO = 40;

  typedef struct packed {
    logic [W-1:0] res;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_err;
  logic [W-1:0] op_a, op_b, entry, result;
  logic [3:0]   op_sel;
  logic         alu_start, result_valid, err, busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_start = 0;
  int   rv_cnt  = 0;
  bit   alu_auto = 1'b1;
  exp_t sb[$];

  always #5 clk = ~clk;

  calc_seq_ctrl #(.WIDTH(W), .ALU_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .alu_start(alu_start),
    .entry(entry), .result(result), .result_valid(result_valid),
    .err(err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] sel);
    case (sel)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == '0) ? '0 : a / b;
      default: return '0;
    endcase
  endfunction

  task automatic send_char(input logic [7:0] c);
    @(posedge clk); #1;
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_rv(input int r0, input int max);
    int k = 0;
    while (rv_cnt == r0 && k < max) begin
      @(negedge clk);
      k++;
    end
    check("rv_seen", rv_cnt != r0, 1);
  endtask

  task automatic pulse_alu_done(input logic [W-1:0] v);
    @(posedge clk); #1;
    alu_result = v;
    alu_done   = 1'b1;
    @(posedge clk); #1;
    alu_done   = 1'b0;
  endtask

  // ALU stand-in: answers two cycles after the start pulse from the operands it was handed
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start && alu_auto) begin
        logic [W-1:0] v;
        v = alu_model(op_a, op_b, op_sel);
        @(posedge clk);
        @(posedge clk); #1;
        alu_result = v;
        alu_err    = 1'b0;
        alu_done   = 1'b1;
        @(posedge clk); #1;
        alu_done   = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (alu_start) n_start++;
      if (result_valid) begin
        exp_t x;
        rv_cnt++;
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          x = sb.pop_front();
          check("sb_result", result, x.res);
          check("sb_err", err, x.e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, lat;
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_op_a", op_a, 0);
    check("rst_op_sel", op_sel, 0);
    check("rst_result", result, 0);
    check("rst_flags", {alu_start, result_valid, err, busy}, 0);
    rst = 1'b1;

    // 12+34= with an ignored 'x' mid-operand
    send_str("12");
    check("entry_12", entry, 12);
    send_char("x");
    check("ignored_char", entry, 12);
    send_char("+");
    check("op_a_12", op_a, 12);
    check("op_sel_add", op_sel, OP_ADD);
    check("entry_cleared", entry, 0);
    send_str("34");
    s0 = n_start; r0 = rv_cnt;
    sb.push_back('{alu_model(12, 34, OP_ADD), 1'b0});
    send_char("=");
    wait_rv(r0, 20);
    check("op_b_34", op_b, 34);
    repeat (4) @(negedge clk);
    check("one_start", n_start - s0, 1);
    check("one_rv", rv_cnt - r0, 1);
    check("result_held", result, 46);

    // divide by zero short-circuits the ALU
    s0 = n_start; r0 = rv_cnt;
    sb.push_back('{'0, 1'b1});
    send_str("8/0=");
    wait_rv(r0, 10);
    check("div0_no_start", n_start - s0, 0);
    check("div0_not_busy", busy, 0);

    // ALU never answers
    alu_auto = 1'b0;
    send_char("C");
    send_str("5*3");
    sb.push_back('{'0, 1'b1});
    r0 = rv_cnt;
    send_char("=");
    lat = 0;
    while (rv_cnt == r0 && lat < TO + 10) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", (lat >= TO) && (lat <= TO + 4), 1);
    r0 = rv_cnt;
    pulse_alu_done(16'd99);
    repeat (3) @(negedge clk);
    check("late_done_ignored", rv_cnt - r0, 0);
    check("late_done_err", err, 1);
    alu_auto = 1'b1;

    // operator handling in OPB
    send_char("C");
    send_str("9+4-");
    check("op_after_digit", op_sel, OP_ADD);
    check("entry_kept", entry, 4);
    send_char("C");
    send_str("9+-");
    check("op_overwrite", op_sel, OP_SUB);
    send_char("4");
    r0 = rv_cnt;
    sb.push_back('{alu_model(9, 4, OP_SUB), 1'b0});
    send_char("=");
    wait_rv(r0, 20);

    // clear while busy, then reset mid-WAIT
    alu_auto = 1'b0;
    send_str("7+2=");
    @(negedge clk);
    check("busy_before_clr", busy, 1);
    send_char("C");
    check("clr_result", result, 0);
    check("clr_ops", {op_a, op_b, op_sel}, 0);
    check("clr_flags", {err, busy}, 0);
    check("clr_entry", entry, 0);
    r0 = rv_cnt;
    pulse_alu_done(16'd9);
    repeat (3) @(negedge clk);
    check("done_after_clr", rv_cnt - r0, 0);
    send_str("7+2=");
    repeat (3) @(negedge clk);
    check("busy_before_rst", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ops", {op_a, op_b, op_sel}, 0);
    check("arst_busy", busy, 0);
    check("arst_entry", entry, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    alu_auto = 1'b1;

    // operand truncation
    send_str("70000+");
    check("trunc_op_a", op_a, W'(70000));
    send_char("1");
    r0 = rv_cnt;
    sb.push_back('{alu_model(W'(70000), 1, OP_ADD), 1'b0});
    send_char("=");
    wait_rv(r0, 20);

    // operator straight after a result
    send_char("C");
    r0 = rv_cnt;
    sb.push_back('{alu_model(12, 34, OP_ADD), 1'b0});
    send_str("12+34=");
    wait_rv(r0, 20);
`ifdef CALC_CHAIN_EN
    r0 = rv_cnt;
    sb.push_back('{alu_model(46, 6, OP_SUB), 1'b0});
    send_str("-6=");
    wait_rv(r0, 20);
    check("chain_op_a", op_a, 46);
    check("chain_result", result, 40);
`else
    r0 = rv_cnt;
    send_str("-6=");
    repeat (6) @(negedge clk);
    check("nochain_op_sel", op_sel, OP_NONE);
    check("nochain_entry", entry, 6);
    check("nochain_no_rv", rv_cnt - r0, 0);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
